// File: rtl/thermal_pwm.sv
// Heater/cooler PWM driver: samples the demand once per 256-tick frame and
// inserts a dead-time interval on every heat<->cool change. Optional ramp: THERMAL_PWM_SOFTSTART_EN.
module thermal_pwm #(
  parameter int PRESCALE   = 1,
  parameter int DEAD_TICKS = 16,
  parameter int SLEW       = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] level,
  input  logic       neg,
  output logic       heat,
  output logic       cool,
  output logic       frame,
  output logic [1:0] state
);

  // state | meaning
  // IDLE  | both outputs off, waiting for the next frame boundary
  // HEAT  | heater PWM at duty_q, cooler off
  // DEAD  | both outputs off for DEAD_TICKS ticks, exits mid-frame to IDLE
  // COOL  | cooler fully on, heater off
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HEAT = 2'b01,
    DEAD = 2'b10,
    COOL = 2'b11
  } state_t;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  generate
    if (SLEW < 1 || SLEW > 255 || DEAD_TICKS < 1 || DEAD_TICKS > 255 || PRESCALE < 1) begin : g_param_out_of_range
    end
  endgenerate

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    dead_q, dead_d;
  logic [7:0]    duty_q, duty_d;
  logic [7:0]    target;
  state_t        st_q, st_d;
  logic          tick, boundary, tick_d;
  logic          heat_d, cool_d, frame_d;

`ifdef THERMAL_PWM_SOFTSTART_EN
  logic [8:0] up, down;
  always_comb begin
    up     = {1'b0, duty_q} + 9'(SLEW);
    down   = {1'b0, duty_q} - 9'(SLEW);
    target = level;
    if (level > duty_q) begin
      if (up < {1'b0, level}) target = up[7:0];
    end else if ({1'b0, duty_q} > 9'(SLEW) + {1'b0, level}) begin
      target = down[7:0];
    end
  end
`else
  always_comb target = level;
`endif

  always_comb begin
    tick     = (presc_q == PMAX);
    boundary = tick && (cnt_q == 8'hFF);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    cnt_d    = tick ? cnt_q + 8'd1 : cnt_q;
    st_d     = st_q;
    dead_d   = dead_q;
    duty_d   = duty_q;

    case (st_q)
      IDLE: if (boundary) begin
        if (neg)                st_d = COOL;
        else if (level != 8'h00) st_d = HEAT;
      end
      HEAT: if (boundary) begin
        if (neg)                 st_d = DEAD;
        else if (level == 8'h00) st_d = IDLE;
      end
      COOL: if (boundary && !neg) st_d = DEAD;
      DEAD: if (tick) begin
        if (dead_q <= 8'd1) begin
          st_d   = IDLE;
          dead_d = 8'd0;
        end else begin
          dead_d = dead_q - 8'd1;
        end
      end
      default: st_d = IDLE;
    endcase

    if (st_d == DEAD && st_q != DEAD) dead_d = 8'(DEAD_TICKS);
    if (boundary) duty_d = (st_d == HEAT) ? target : 8'h00;

    // Registered outputs are built from next-cycle values so they line up with state/cnt/duty_q.
    tick_d  = (presc_d == PMAX);
    heat_d  = (st_d == HEAT) && (cnt_d < duty_d);
    cool_d  = (st_d == COOL);
    frame_d = tick_d && (cnt_d == 8'hFF);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      cnt_q   <= 8'd0;
      dead_q  <= 8'd0;
      duty_q  <= 8'd0;
      st_q    <= IDLE;
      heat    <= 1'b0;
      cool    <= 1'b0;
      frame   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      dead_q  <= dead_d;
      duty_q  <= duty_d;
      st_q    <= st_d;
      heat    <= heat_d;
      cool    <= cool_d;
      frame   <= frame_d;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_thermal_pwm.sv
// Bench for thermal_pwm: frame-position reference model feeding a scoreboard,
// a demand vector table, and hand-written dead-time, reset and soft-start sequences.
module tb_thermal_pwm;

  localparam int P  = 1;
  localparam int DT = 16;
  localparam int SL = 16;
  localparam int FR = 256 * P;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] level = 8'h00;
  logic       neg   = 1'b0;
  logic       heat, cool, frame;
  logic [1:0] state;

  thermal_pwm #(.PRESCALE(P), .DEAD_TICKS(DT), .SLEW(SL)) dut (
    .clock(clock), .reset(reset), .level(level), .neg(neg),
    .heat(heat), .cool(cool), .frame(frame), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       heat;
    logic       cool;
    logic       frame;
    logic [1:0] st;
  } obs_t;

  typedef struct {
    logic [7:0] level;
    logic       neg;
    logic [1:0] exp_state;
    int         exp_heat;
    int         exp_cool;
  } vec_t;

  obs_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  int         t;
  logic [1:0] m_st, m_nx;
  int         m_duty, m_dead;
  logic       m_bnd;

  function automatic int next_duty(input int d, input int lv);
`ifdef THERMAL_PWM_SOFTSTART_EN
    if (lv > d) return (lv - d > SL) ? d + SL : lv;
    return (d - lv > SL) ? d - SL : lv;
`else
    return lv + 0 * d;
`endif
  endfunction

  // Reference model: position in the frame comes from the absolute cycle count since reset.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      t = 0; m_st = 2'b00; m_duty = 0; m_dead = 0;
      sbq.delete();
    end else begin
      m_bnd = ((t % FR) == FR - 1);
      m_nx  = m_st;
      if (m_st == 2'b10) begin
        m_dead = m_dead - 1;
        if (m_dead == 0) m_nx = 2'b00;
      end else if (m_bnd) begin
        case (m_st)
          2'b00: m_nx = neg ? 2'b11 : (level != 0 ? 2'b01 : 2'b00);
          2'b01: m_nx = neg ? 2'b10 : (level == 0 ? 2'b00 : 2'b01);
          default: m_nx = neg ? 2'b11 : 2'b10;
        endcase
      end
      if (m_nx == 2'b10 && m_st != 2'b10) m_dead = DT * P;
      if (m_bnd) m_duty = (m_nx == 2'b01) ? next_duty(m_duty, int'(level)) : 0;
      m_st = m_nx;
      t = t + 1;
      sbq.push_back('{heat: (m_st == 2'b01) && (((t / P) % 256) < m_duty),
                      cool: (m_st == 2'b11),
                      frame: ((t % FR) == FR - 1),
                      st: m_st});
    end
  end

  always @(negedge clock) begin
    obs_t e;
    if (reset && sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if ({heat, cool, frame, state} !== e) begin
        failures++;
        $display("FAIL cycle t=%0d got heat=%b cool=%b frame=%b state=%b want heat=%b cool=%b frame=%b state=%b",
                 t, heat, cool, frame, state, e.heat, e.cool, e.frame, e.st);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic wait_pos(input int pos);
    for (int k = 0; k <= FR + 1; k++) begin
      @(negedge clock);
      if ((t % FR) == pos) return;
    end
    check("wait_pos_timeout", 0, 1);
  endtask

  task automatic count_frame(output int hc, output int cc, output int dc, output int st_last);
    hc = 0; cc = 0; dc = 0;
    for (int k = 0; k < FR; k++) begin
      if (k > 0) @(negedge clock);
      hc += int'(heat);
      cc += int'(cool);
      dc += (state == 2'b10) ? 1 : 0;
      if (heat && cool) check("heat_and_cool", 1, 0);
    end
    st_last = int'(state);
  endtask

  vec_t vecs[10];
  int hc, cc, dc, sl;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h80, 1'b0, 2'b01, 128, 0};
    vecs[1] = '{8'hFF, 1'b0, 2'b01, 255, 0};
    vecs[2] = '{8'h00, 1'b0, 2'b00, 0,   0};
    vecs[3] = '{8'h01, 1'b0, 2'b01, 1,   0};
    vecs[4] = '{8'h40, 1'b1, 2'b11, 0,   256};
    vecs[5] = '{8'hFF, 1'b1, 2'b11, 0,   256};
    vecs[6] = '{8'hFF, 1'b0, 2'b01, 255, 0};
    vecs[7] = '{8'h00, 1'b1, 2'b11, 0,   256};
    vecs[8] = '{8'h00, 1'b0, 2'b00, 0,   0};
    vecs[9] = '{8'hC0, 1'b0, 2'b01, 192, 0};

    #2;
    check("reset_outputs", int'({heat, cool, frame, state}), 0);
    #21 reset = 1'b1;

    for (int k = 0; k <= FR + 2; k++) begin
      @(negedge clock);
      if (frame) break;
    end
    check("first_frame_cycle", t, FR - 1);

`ifdef THERMAL_PWM_SOFTSTART_EN
    level = 8'hFF;
    wait_pos(0);
    for (int i = 0; i < 17; i++) begin
      count_frame(hc, cc, dc, sl);
      check("softstart_duty", hc, (16 * (i + 1) > 255) ? 255 : 16 * (i + 1));
      wait_pos(0);
    end
    level = 8'h00;
    wait_pos(0);
`endif

    foreach (vecs[i]) begin
      wait_pos(40);
      level = vecs[i].level;
      neg   = vecs[i].neg;
      wait_pos(0);
      wait_pos(0);
      count_frame(hc, cc, dc, sl);
      check($sformatf("vec%0d_state", i), sl, int'(vecs[i].exp_state));
      check($sformatf("vec%0d_cool", i), cc, vecs[i].exp_cool);
`ifndef THERMAL_PWM_SOFTSTART_EN
      check($sformatf("vec%0d_heat", i), hc, vecs[i].exp_heat);
`endif
    end

    // Heat->cool with mid-frame glitches on both demand inputs.
    wait_pos(40);
    level = 8'h80;
    wait_pos(0);
    wait_pos(40);
    neg = 1'b1; level = 8'h00;
    wait_pos(60);
    neg = 1'b0; level = 8'h80;
    wait_pos(70);
    neg = 1'b1;
    wait_pos(200);
    check("glitch_still_heat", int'(state), 1);
    wait_pos(0);
    count_frame(hc, cc, dc, sl);
    check("dead_cycles", dc, DT * P);
    check("dead_frame_outputs_off", hc + cc, 0);
    check("after_dead_idle", sl, 0);
    wait_pos(0);
    count_frame(hc, cc, dc, sl);
    check("cool_full_frame", cc, FR);
    check("cool_frame_no_heat", hc, 0);

    // Cool->heat, then reset asynchronously in the middle of a heat frame.
    wait_pos(40);
    neg = 1'b0; level = 8'hFF;
    wait_pos(0);
    count_frame(hc, cc, dc, sl);
    check("cool2heat_dead_cycles", dc, DT * P);
    check("cool2heat_off_frame", hc + cc, 0);
    wait_pos(100);
    check("pre_reset_heat_state", int'(state), 1);
    #2 reset = 1'b0;
    #1 check("async_reset_outputs", int'({heat, cool, frame, state}), 0);
    #9 reset = 1'b1;
    count_frame(hc, cc, dc, sl);
    check("post_reset_outputs_off", hc + cc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
